// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, requester FSM states and the
// response record. Also imported by the APB completer.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester. A valid/ready command becomes one
// SETUP + ACCESS transfer. The result comes back on a valid/ready response
// port. A wait-state watchdog aborts a transfer when the completer holds
// PREADY low for TIMEOUT consecutive ACCESS cycles.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // The counter stays at least one bit wide so that TIMEOUT=0 still elaborates.
  // In that case the counter is never compared.
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  apb_mst_state_e   state;
  logic [CNT_W-1:0] wait_cnt;
  logic             watchdog_hit;

  // Accept only from IDLE. This is decoded from state alone, so there is no
  // path from rsp_ready.
  assign cmd_ready = (state == APB_IDLE);

  // Watchdog expiry: this is the last permitted ACCESS cycle with PREADY low.
  assign watchdog_hit = WDOG_EN && (wait_cnt == CNT_LAST);

  // Transfer sequencer. All bus and response outputs are registered here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= APB_IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        APB_IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PSEL   <= 1'b1;
            state  <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // PREADY wins over a watchdog expiry in the same cycle.
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= APB_RESP;
          end else if (watchdog_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= APB_RESP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        APB_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= APB_IDLE;
          end
        end
        default: state <= APB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4). A small completer model
// drives PREADY/PRDATA/PSLVERR from the observed bus phase. Outputs are
// sampled on the falling edge.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completer outside a ready ACCESS cycle: junk that must be ignored.
  task automatic bus_idle_junk();
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hFFFF_FFFF;
  endtask

  // Run one transfer. waits < 0 means PREADY never rises.
  // bp = cycles with rsp_ready low, during which cmd_valid is held high.
  task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int waits,
                      input logic [DW-1:0] prd, input logic err_in,
                      input logic [DW-1:0] exp_rd, input logic exp_err,
                      input logic exp_to, input int exp_en, input int bp);
    int sel_cyc, en_cyc, lat, bad_hold, bad_rdy;
    bit done;
    logic rdy;
    sel_cyc = 0; en_cyc = 0; lat = 0; bad_hold = 0; bad_rdy = 0; done = 0;
    // Start at a falling edge with the bridge in IDLE.
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    rsp_ready = 1'b0;
    bus_idle_junk();
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    @(posedge PCLK);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge PCLK);
      lat++;
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        done = 1;
      end else begin
        if (cmd_ready) bad_rdy++;
        if (PSEL) begin
          sel_cyc++;
          if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) bad_hold++;
        end
        if (PENABLE) begin
          en_cyc++;
          rdy = (waits >= 0) && (en_cyc > waits);
          PREADY  = rdy;
          PSLVERR = rdy ? err_in : 1'b1;
          PRDATA  = rdy ? prd : 32'hFFFF_FFFF;
        end else begin
          bus_idle_junk();
        end
      end
    end
    bus_idle_junk();
    chk({tag, "_done"},     done, 1);
    chk({tag, "_latency"},  lat, exp_en + 2);
    chk({tag, "_psel_cyc"}, sel_cyc, exp_en + 1);
    chk({tag, "_pen_cyc"},  en_cyc, exp_en);
    chk({tag, "_bus_hold"}, bad_hold, 0);
    chk({tag, "_busy_rdy"}, bad_rdy, 0);
    chk({tag, "_psel_off"}, {PSEL, PENABLE}, 2'b00);
    chk({tag, "_rdata"},    rsp_rdata, exp_rd);
    chk({tag, "_err"},      rsp_err, exp_err);
    chk({tag, "_timeout"},  rsp_timeout, exp_to);
    // Back-pressure: the response must stay put and no command may be taken.
    bad_hold = 0; bad_rdy = 0;
    for (int c = 0; c < bp; c++) begin
      cmd_valid = 1'b1;
      @(negedge PCLK);
      if (cmd_ready || PSEL) bad_rdy++;
      if (!rsp_valid || rsp_rdata !== exp_rd || rsp_err !== exp_err ||
          rsp_timeout !== exp_to) bad_hold++;
    end
    if (bp > 0) begin
      chk({tag, "_bp_rdy"},  bad_rdy, 0);
      chk({tag, "_bp_hold"}, bad_hold, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_clr"},   rsp_valid, 0);
    chk({tag, "_idle_rdy"},  cmd_ready, 1);
  endtask

  initial begin
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    bus_idle_junk();
    repeat (2) @(negedge PCLK);
    chk("rst_bus",   {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp",   {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Write with zero waits: PREADY high throughout.
    xfer("wr0", 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0,
         32'h0, 1'b0, 1'b0, 1, 0);
    chk("wr0_paddr_kept",  PADDR, 32'h10);
    chk("wr0_pwdata_kept", PWDATA, 32'hDEAD_BEEF);
    // Read with two wait states.
    xfer("rd2", 1'b0, 32'h20, 32'h0, 2, 32'h1234_5678, 1'b0,
         32'h1234_5678, 1'b0, 1'b0, 3, 0);
    // Slave error on a read.
    xfer("err", 1'b0, 32'h24, 32'h0, 0, 32'h0000_AAAA, 1'b1,
         32'h0000_AAAA, 1'b1, 1'b0, 1, 0);
    // Watchdog: PREADY never rises, so the transfer aborts after 4 ACCESS cycles.
    xfer("tmo", 1'b0, 32'h30, 32'h0, -1, 32'h0, 1'b0,
         32'h0, 1'b1, 1'b1, TO, 0);
    // Boundary: PREADY rises on the 4th ACCESS cycle and wins over the watchdog.
    xfer("tmo_edge", 1'b0, 32'h34, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0,
         32'hCAFE_0001, 1'b0, 1'b0, TO, 0);
    // Back-pressure for 5 cycles with cmd_valid held, then a back-to-back command.
    xfer("bp", 1'b1, 32'h40, 32'h0BAD_F00D, 0, 32'h0, 1'b1,
         32'h0, 1'b1, 1'b0, 1, 5);
    xfer("b2b", 1'b0, 32'h44, 32'h0, 1, 32'h8765_4321, 1'b0,
         32'h8765_4321, 1'b0, 1'b0, 2, 0);

    // Reset during ACCESS: the bus and the response drop at once.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    PREADY = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("mid_pen_before", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("mid_async_bus", {PSEL, PENABLE, rsp_valid}, 3'b000);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY = 1'b1;
    chk("mid_cmd_ready", cmd_ready, 1);
    begin
      int spur;
      spur = 0;
      repeat (6) begin
        @(negedge PCLK);
        if (rsp_valid || PSEL || !cmd_ready) spur++;
      end
      chk("mid_no_rsp", spur, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound in case a wait never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
